// File: rtl/adma_descriptor_fetch.sv
// Fetches one 96-bit ADMA2 descriptor as three 32-bit single-beat reads and
// presents it with decoded fields; reports misalignment, timeout and bus errors.
module adma_descriptor_fetch #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] sys_adr,
    input  logic              abort,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rerr,
    output logic              busy,
    output logic              desc_done,
    output logic              fetch_err,
    output logic [1:0]        err_code,
    output logic [95:0]       descriptor,
    output logic              desc_valid,
    output logic              desc_end,
    output logic              desc_int,
    output logic [1:0]        desc_act,
    output logic [15:0]       desc_len,
    output logic [63:0]       desc_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        beat;
    logic [ADDR_W-1:0] base;
    logic [TO_W-1:0]   tcnt;
    logic [31:0]       word0;
    logic [31:0]       word1;
    logic              expired;

    assign expired = (tcnt == TO_W'(TIMEOUT_CYC - 1));

    // In REQ expiry beats a same-cycle grant, so the counter never runs past the limit.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch_start) begin
                    state_nxt = (sys_adr[1:0] == 2'b00) ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (expired) begin
                    state_nxt = S_ERR;
                end else if (mem_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (mem_rerr) begin
                        state_nxt = S_ERR;
                    end else if (beat == 2'd2) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end else if (expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            beat       <= '0;
            base       <= '0;
            tcnt       <= '0;
            word0      <= '0;
            word1      <= '0;
            descriptor <= '0;
            err_code   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && state_nxt == S_REQ) begin
                base <= sys_adr;
                beat <= '0;
            end
            if (state != S_REQ && state_nxt == S_REQ) begin
                tcnt <= '0;
            end else if (state == S_REQ || state == S_WAIT) begin
                tcnt <= tcnt + TO_W'(1);
            end
            if (state == S_WAIT && state_nxt == S_REQ) begin
                beat <= beat + 2'd1;
                if (beat == 2'd0) begin
                    word0 <= mem_rdata;
                end else begin
                    word1 <= mem_rdata;
                end
            end
            // Third word is assembled on the way into DONE so the pulse sees fresh data.
            if (state_nxt == S_DONE) begin
                descriptor <= {mem_rdata, word1, word0};
            end
            if (state_nxt == S_ERR) begin
                if (state == S_IDLE) begin
                    err_code <= 2'b01;
                end else if (state == S_WAIT && mem_rvalid) begin
                    err_code <= 2'b11;
                end else begin
                    err_code <= 2'b10;
                end
            end
        end
    end

    assign mem_req    = (state == S_REQ);
    assign mem_addr   = base + ADDR_W'({beat, 2'b00});
    assign busy       = (state != S_IDLE);
    assign desc_done  = (state == S_DONE);
    assign fetch_err  = (state == S_ERR);
    assign desc_valid = descriptor[0];
    assign desc_end   = descriptor[1];
    assign desc_int   = descriptor[2];
    assign desc_act   = descriptor[5:4];
    assign desc_len   = descriptor[31:16];
    assign desc_addr  = descriptor[95:32];

endmodule
